// File: rtl/scalar_mult_ctrl_pkg.sv
// Shared definitions for the double-and-add scalar multiplication controller:
// default width, point-op codes and the FSM state encoding.
package scalar_mult_ctrl_pkg;

  localparam int N_BITS = 255;

  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INIT     = 4'd1,
    DBL_REQ  = 4'd2,
    DBL_WAIT = 4'd3,
    DBL_WB   = 4'd4,
    ADD_REQ  = 4'd5,
    ADD_WAIT = 4'd6,
    ADD_WB   = 4'd7,
    NEXT     = 4'd8,
    FIN      = 4'd9
  } state_t;

endpackage

// File: rtl/scalar_mult_ctrl.sv
// Double-and-add scalar multiplication sequencer: walks the scalar MSB first and
// issues DOUBLE/ADD point-op requests to an external arithmetic unit.
module scalar_mult_ctrl #(
  parameter int N_BITS = scalar_mult_ctrl_pkg::N_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_BITS-1:0] scalar,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              op_valid,
  output logic              op_type,
  input  logic              op_ready,
  input  logic              res_valid,
  input  logic [N_BITS-1:0] res_X,
  input  logic [N_BITS-1:0] res_Y,
  input  logic [N_BITS-1:0] res_Z,
  input  logic [N_BITS-1:0] res_T,
  output logic              acc_init,
  output logic              acc_we,
  output logic [N_BITS-1:0] acc_X,
  output logic [N_BITS-1:0] acc_Y,
  output logic [N_BITS-1:0] acc_Z,
  output logic [N_BITS-1:0] acc_T,
  output logic [7:0]        bit_idx,
  output logic [3:0]        fsm_state
);
  import scalar_mult_ctrl_pkg::*;

  localparam logic [7:0] IDX_MSB = 8'(N_BITS - 1);

  state_t            state;
  state_t            next_state;
  logic [N_BITS-1:0] scalar_q;
  logic              in_wait;

  assign fsm_state = state;
  assign in_wait   = (state == DBL_WAIT) || (state == ADD_WAIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort overrides every busy state, including a
  // request that op_ready would otherwise accept in the same cycle.
  always_comb begin
    next_state = state;
    if (state != IDLE && abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) next_state = INIT;
        INIT:     next_state = DBL_REQ;
        DBL_REQ:  if (op_ready) next_state = DBL_WAIT;
        DBL_WAIT: if (res_valid) next_state = DBL_WB;
        DBL_WB:   next_state = scalar_q[bit_idx] ? ADD_REQ : NEXT;
        ADD_REQ:  if (op_ready) next_state = ADD_WAIT;
        ADD_WAIT: if (res_valid) next_state = ADD_WB;
        ADD_WB:   next_state = NEXT;
        NEXT:     next_state = (bit_idx == 8'd0) ? FIN : DBL_REQ;
        FIN:      next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  // Request handshake: a point op transfers in the cycle where op_valid and
  // op_ready are both high; op_valid stays high with a stable op_type until
  // then. Strobes are masked during abort so nothing transfers or completes.
  always_comb begin
    busy     = (state != IDLE);
    done     = 1'b0;
    op_valid = 1'b0;
    op_type  = OP_DBL;
    acc_init = 1'b0;
    acc_we   = 1'b0;
    case (state)
      INIT:    acc_init = !abort;
      DBL_REQ: op_valid = !abort;
      ADD_REQ: begin
        op_valid = !abort;
        op_type  = OP_ADD;
      end
      DBL_WB:  acc_we = !abort;
      ADD_WB:  acc_we = !abort;
      FIN:     done = !abort;
      default: ;
    endcase
  end

  // Scalar capture, bit counter and accumulator write-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scalar_q <= '0;
      bit_idx  <= '0;
      acc_X    <= '0;
      acc_Y    <= '0;
      acc_Z    <= '0;
      acc_T    <= '0;
    end else begin
      if (state == IDLE && start) begin
        scalar_q <= scalar;
        bit_idx  <= IDX_MSB;
      end
      if (!abort) begin
        if (in_wait && res_valid) begin
          acc_X <= res_X;
          acc_Y <= res_Y;
          acc_Z <= res_Z;
          acc_T <= res_T;
        end
        if (state == NEXT && bit_idx != 8'd0) begin
          bit_idx <= bit_idx - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: an expected op sequence built from the scalar,
// a simple arithmetic-unit responder and per-cycle output checks.
`timescale 1ns/1ps
module tb_scalar_mult_ctrl;
  import scalar_mult_ctrl_pkg::*;

  localparam int N = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         op_ready = 1'b0;
  logic         res_valid = 1'b0;
  logic [N-1:0] scalar = '0;
  logic [N-1:0] res_X = '0, res_Y = '0, res_Z = '0, res_T = '0;
  logic         busy, done, op_valid, op_type, acc_init, acc_we;
  logic [N-1:0] acc_X, acc_Y, acc_Z, acc_T;
  logic [7:0]   bit_idx;
  logic [3:0]   fsm_state;

  always #5 clk = ~clk;

  scalar_mult_ctrl #(.N_BITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scalar(scalar), .abort(abort),
    .busy(busy), .done(done), .op_valid(op_valid), .op_type(op_type),
    .op_ready(op_ready), .res_valid(res_valid),
    .res_X(res_X), .res_Y(res_Y), .res_Z(res_Z), .res_T(res_T),
    .acc_init(acc_init), .acc_we(acc_we),
    .acc_X(acc_X), .acc_Y(acc_Y), .acc_Z(acc_Z), .acc_T(acc_T),
    .bit_idx(bit_idx), .fsm_state(fsm_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Expected op stream: {op_type, bit_idx}
  logic [8:0]   exp_q[$];
  logic [N-1:0] exp_acc[4];

  int d_cnt, a_cnt, we_cnt, init_cnt, done_cnt;
  logic       last_typ;
  logic [7:0] last_idx;

  logic         s_done, s_busy, s_op_valid, s_op_type, s_acc_we;
  logic [7:0]   s_bit_idx;
  logic [3:0]   s_state;
  logic [N-1:0] s_acc_X;

  logic       prev_pend = 1'b0;
  logic       prev_typ = 1'b0;
  logic [7:0] prev_idx = 8'd0;

  logic hs_seen = 1'b0;
  logic rsp_pend = 1'b0;
  logic spur_req = 1'b0;
  int   rsp_wait = 0;
  int   rsp_seq = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_wide(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] pat(input int k);
    logic [255:0] v;
    v = {8{32'(k) ^ 32'h9E37_79B9}};
    return v[N-1:0];
  endfunction

  // MSB-first double-and-add: one DOUBLE per bit, an ADD after it when the bit is set
  task automatic build_model(input logic [N-1:0] k);
    exp_q.delete();
    for (int i = N - 1; i >= 0; i--) begin
      exp_q.push_back({OP_DBL, 8'(i)});
      if (k[i]) exp_q.push_back({OP_ADD, 8'(i)});
    end
  endtask

  task automatic sample();
    @(negedge clk);
    s_done = done; s_busy = busy; s_op_valid = op_valid; s_op_type = op_type;
    s_acc_we = acc_we; s_bit_idx = bit_idx; s_state = fsm_state; s_acc_X = acc_X;
    check("strobe_exclusive", 64'($countones({acc_init, acc_we, done}) <= 1), 64'd1);
    if (rst_n && !abort && prev_pend) begin
      check("held_op_valid", 64'(op_valid), 64'd1);
      check("held_op_type", 64'(op_type), 64'(prev_typ));
      check("held_bit_idx", 64'(bit_idx), 64'(prev_idx));
    end
    prev_pend = op_valid && !op_ready;
    prev_typ  = op_type;
    prev_idx  = bit_idx;
    if (op_valid && op_ready) begin
      hs_seen = 1'b1;
      if (op_type) a_cnt++; else d_cnt++;
      last_typ = op_type;
      last_idx = bit_idx;
      check("op_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("op_seq", 64'({op_type, bit_idx}), 64'(exp_q.pop_front()));
    end
    if (acc_init) init_cnt++;
    if (acc_we) begin
      we_cnt++;
      check_wide("acc_X", acc_X, exp_acc[0]);
      check_wide("acc_Y", acc_Y, exp_acc[1]);
      check_wide("acc_Z", acc_Z, exp_acc[2]);
      check_wide("acc_T", acc_T, exp_acc[3]);
    end
    if (done) begin
      done_cnt++;
      check("ops_left_at_done", 64'(exp_q.size()), 64'd0);
    end
  endtask

  // Arithmetic unit: answers each accepted op after 0..2 idle cycles
  task automatic respond();
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    if (hs_seen) begin
      rsp_pend = 1'b1;
      rsp_wait = rsp_seq % 3;
      hs_seen  = 1'b0;
    end
    if (rsp_pend) begin
      if (rsp_wait == 0) begin
        rsp_seq++;
        res_X = pat(rsp_seq * 4);     res_Y = pat(rsp_seq * 4 + 1);
        res_Z = pat(rsp_seq * 4 + 2); res_T = pat(rsp_seq * 4 + 3);
        exp_acc[0] = res_X; exp_acc[1] = res_Y; exp_acc[2] = res_Z; exp_acc[3] = res_T;
        res_valid = 1'b1;
        rsp_pend  = 1'b0;
      end else begin
        rsp_wait--;
      end
    end else if (spur_req) begin
      res_X = ~pat(7); res_Y = ~pat(8); res_Z = ~pat(9); res_T = ~pat(10);
      res_valid = 1'b1;
      spur_req  = 1'b0;
    end
  endtask

  task automatic tick();
    sample();
    respond();
  endtask

  task automatic clear_env();
    exp_q.delete();
    hs_seen = 1'b0; rsp_pend = 1'b0; spur_req = 1'b0; prev_pend = 1'b0;
  endtask

  task automatic start_run(input logic [N-1:0] k);
    d_cnt = 0; a_cnt = 0; we_cnt = 0; init_cnt = 0; done_cnt = 0;
    build_model(k);
    scalar = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!s_done && c < 8000) begin
      tick();
      c++;
    end
    check({name, "_done_seen"}, 64'(s_done), 64'd1);
    tick();
    check({name, "_done_one_cycle"}, 64'(s_done), 64'd0);
    check({name, "_idle_after"}, 64'(s_busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_op_valid"}, 64'(op_valid), 64'd0);
    check({tag, "_op_type"}, 64'(op_type), 64'd0);
    check({tag, "_acc_init"}, 64'(acc_init), 64'd0);
    check({tag, "_acc_we"}, 64'(acc_we), 64'd0);
    check({tag, "_bit_idx"}, 64'(bit_idx), 64'd0);
    check({tag, "_state"}, 64'(fsm_state), 64'(IDLE));
    check_wide({tag, "_acc_X"}, acc_X, '0);
    check_wide({tag, "_acc_Y"}, acc_Y, '0);
    check_wide({tag, "_acc_Z"}, acc_Z, '0);
    check_wide({tag, "_acc_T"}, acc_T, '0);
  endtask

  initial begin
    int c;
    int ops_before, we_before, done_before;
    logic [3:0]   st0;
    logic [N-1:0] acc0;
    logic [N-1:0] ones;
    ones = '1;

    // Power-on reset
    repeat (3) tick();
    check_reset_outputs("por");
    rst_n = 1'b1;
    op_ready = 1'b1;
    repeat (2) tick();
    check("por_idle_after_release", 64'(s_busy), 64'd0);

    // Model pinned by hand: k=5 -> 255 doubles + 2 adds, first D@254, last A@0
    build_model(255'd5);
    check("model_len_k5", 64'(exp_q.size()), 64'd257);
    check("model_first_k5", 64'(exp_q[0]), 64'h0FE);
    check("model_last_k5", 64'(exp_q[exp_q.size() - 1]), 64'h100);
    exp_q.delete();

    // scalar = 1
    start_run(255'd1);
    wait_done("k1");
    check("k1_doubles", 64'(d_cnt), 64'd255);
    check("k1_adds", 64'(a_cnt), 64'd1);
    check("k1_acc_we", 64'(we_cnt), 64'd256);
    check("k1_acc_init", 64'(init_cnt), 64'd1);
    check("k1_done", 64'(done_cnt), 64'd1);

    // scalar = 0
    start_run(255'd0);
    wait_done("k0");
    check("k0_doubles", 64'(d_cnt), 64'd255);
    check("k0_adds", 64'(a_cnt), 64'd0);
    check("k0_acc_we", 64'(we_cnt), 64'd255);
    check("k0_done", 64'(done_cnt), 64'd1);

    // scalar = all ones
    start_run(ones);
    wait_done("kff");
    check("kff_ops", 64'(d_cnt + a_cnt), 64'd510);
    check("kff_adds", 64'(a_cnt), 64'd255);
    check("kff_last_type", 64'(last_typ), 64'd1);
    check("kff_last_idx", 64'(last_idx), 64'd0);

    // op_ready held low in the first DBL_REQ, with a stray res_valid
    op_ready = 1'b0;
    start_run(255'h3C);
    c = 0;
    while (!s_op_valid && c < 10) begin
      tick();
      c++;
    end
    check("stall_reached_req", 64'(s_op_valid), 64'd1);
    st0 = s_state;
    acc0 = s_acc_X;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) spur_req = 1'b1;
      tick();
      check("stall_op_valid", 64'(s_op_valid), 64'd1);
      check("stall_op_type", 64'(s_op_type), 64'd0);
      check("stall_bit_idx", 64'(s_bit_idx), 64'd254);
      check("stall_state", 64'(s_state), 64'(st0));
      check_wide("stall_acc_hold", s_acc_X, acc0);
    end
    op_ready = 1'b1;
    wait_done("stall");
    check("stall_adds", 64'(a_cnt), 64'd4);
    check("stall_doubles", 64'(d_cnt), 64'd255);

    // start mid-run with a different scalar is ignored
    start_run(255'hF0);
    repeat (60) tick();
    scalar = ones;
    start = 1'b1;
    tick();
    start = 1'b0;
    scalar = '0;
    wait_done("restart");
    check("restart_adds", 64'(a_cnt), 64'd4);
    check("restart_acc_init", 64'(init_cnt), 64'd1);

    // abort on a request at bit 50 with op_ready high
    start_run(ones);
    c = 0;
    while (!(op_valid && bit_idx == 8'd50) && c < 8000) begin
      tick();
      c++;
    end
    check("abort_req_reached", 64'(op_valid && bit_idx == 8'd50), 64'd1);
    ops_before = d_cnt + a_cnt;
    done_before = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_req_no_handshake", 64'(d_cnt + a_cnt), 64'(ops_before));
    check("abort_req_no_done", 64'(s_done), 64'd0);
    tick();
    check("abort_req_idle", 64'(s_busy), 64'd0);
    clear_env();
    repeat (5) tick();
    check("abort_req_no_done_after", 64'(done_cnt), 64'(done_before));
    check("abort_req_stays_idle", 64'(s_busy), 64'd0);

    // abort on a write-back cycle at bit 50
    start_run(ones);
    c = 0;
    while (!(acc_we && bit_idx == 8'd50) && c < 8000) begin
      tick();
      c++;
    end
    check("abort_wb_reached", 64'(acc_we && bit_idx == 8'd50), 64'd1);
    we_before = we_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_wb_no_acc_we", 64'(s_acc_we), 64'd0);
    check("abort_wb_we_count", 64'(we_cnt), 64'(we_before));
    tick();
    check("abort_wb_idle", 64'(s_busy), 64'd0);
    clear_env();
    repeat (5) tick();

    // asynchronous reset mid-operation at bit 100
    start_run(ones);
    c = 0;
    while (!(busy && bit_idx == 8'd100) && c < 8000) begin
      tick();
      c++;
    end
    check("rst_point_reached", 64'(bit_idx), 64'd100);
    done_before = done_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    clear_env();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("midrst_idle_after", 64'(s_busy), 64'd0);
    check("midrst_no_done", 64'(done_cnt), 64'(done_before));

    // fresh start after reset runs normally
    start_run(255'd1);
    wait_done("post_rst");
    check("post_rst_doubles", 64'(d_cnt), 64'd255);
    check("post_rst_adds", 64'(a_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/scalar_mult_ctrl.md
SCALAR_MULT_CTRL -- requirements
Module: scalar_mult_ctrl

Interface
REQ-001 The parameter SHALL be N_BITS, default 255, giving the scalar width and the accumulator coordinate width.
REQ-002 clk  in  1  Single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  in  1  Asynchronous, active-low reset.
REQ-004 start  in  1  Begin scalar multiplication; sampled only in IDLE.
REQ-005 scalar  in  N_BITS  Scalar k; captured on accepted start.
REQ-006 abort  in  1  Synchronous abort; returns to IDLE without done.
REQ-007 busy  out  1  High in every state except IDLE.
REQ-008 done  out  1  One-cycle pulse on completion.
REQ-009 op_valid  out  1  Point-op request to the arithmetic unit.
REQ-010 op_type  out  1  0 = DOUBLE(acc), 1 = ADD(acc, base).
REQ-011 op_ready  in  1  Arithmetic unit accepts the request.
REQ-012 res_valid  in  1  Arithmetic unit result strobe.
REQ-013 res_X, res_Y, res_Z, res_T  in  N_BITS each  Result point, extended coordinates.
REQ-014 acc_init  out  1  One-cycle pulse; clears the accumulator register file to the identity (0,1,1,0).
REQ-015 acc_we  out  1  Write enable; drives all four coordinate write enables of the accumulator.
REQ-016 acc_X, acc_Y, acc_Z, acc_T  out  N_BITS each  Registered write data to the accumulator.
REQ-017 bit_idx  out  8  Index of the scalar bit currently processed.

Function
REQ-018 The FSM SHALL have the states IDLE, INIT, DBL_REQ, DBL_WAIT, DBL_WB, ADD_REQ, ADD_WAIT, ADD_WB, NEXT and FIN.
REQ-019 IDLE transition: start=1 captures scalar, sets bit_idx=N_BITS-1 and goes to INIT.
REQ-020 INIT behaviour: assert acc_init for exactly one cycle, then go to DBL_REQ.
REQ-021 REQ states (op_valid, op_type):
- op_valid=1 in DBL_REQ and ADD_REQ.
- op_type is constant while op_valid is high.
- Handshake completes on op_valid & op_ready in the same cycle.
- Next state is the matching WAIT state.
REQ-022 WAIT states (capture):
- res_valid=1 captures res_X..res_T into acc_X..acc_T.
- Next state is the matching WB state.
- res_valid is ignored in all other states.
REQ-023 WB states: assert acc_we for exactly one cycle.
- DBL_WB goes to ADD_REQ if scalar[bit_idx]=1, else to NEXT.
- ADD_WB goes to NEXT.
REQ-024 NEXT: if bit_idx=0 go to FIN, else decrement bit_idx and go to DBL_REQ.
REQ-025 FIN: pulse done for one cycle, then go to IDLE.
REQ-026 Operation count:
- Total = N_BITS doubles + popcount(scalar) adds.
- Processing is MSB first; every bit is processed, with no leading-zero skip.
REQ-027 start while busy SHALL be ignored, and scalar SHALL NOT be recaptured.
REQ-028 abort handling:
- abort=1 in any busy state goes to IDLE next cycle.
- No done and no acc_we is asserted on the abort cycle.
- If abort and op_ready coincide, abort wins.
REQ-029 acc_init, acc_we and done SHALL be mutually exclusive in every cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force the following, including mid-operation:
- state = IDLE.
- busy, done, op_valid, op_type, acc_init and acc_we = 0.
- acc_X..acc_T = 0, bit_idx = 0, captured scalar = 0.
REQ-031 After rst_n deasserts, the block SHALL wait for a new start; no operation resumes.

Structure
REQ-032 A shared package SHALL hold N_BITS, the op codes OP_DBL=1'b0 and OP_ADD=1'b1, and the FSM state enum.
REQ-033 The block SHALL be a single module with no sub-module; the bit counter and FSM are inline.

Verification
REQ-034 scalar=1 -> exactly 255 DOUBLE then 1 ADD.
- Exactly 256 acc_we pulses, one acc_init, one done.
REQ-035 scalar=0 -> 255 DOUBLE and 0 ADD.
- done asserted after the final DBL_WB/NEXT.
REQ-036 scalar=all-ones -> 510 ops alternating D,A.
- Last op is ADD with bit_idx=0.
REQ-037 op_ready held low 5 cycles in DBL_REQ:
- op_valid stays high and op_type stays 0 throughout.
- No state advance.
- res_valid pulsed during this time is ignored.
REQ-038 start pulsed mid-run with a different scalar -> ignored; op sequence matches the original scalar.
REQ-039 rst_n low at bit_idx=100 -> all outputs at reset values within the same cycle, IDLE after release; abort at bit_idx=50 -> IDLE next cycle, no done.
